// File: rtl/wb_prefetch_if.sv
// Wishbone classic bus bundle between the prefetch master and the boot ROM slave.
// Signal names follow the master's point of view (_o driven by master, _i driven by slave).
interface wb_prefetch_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_prefetch.sv
// Sequential instruction prefetcher: Wishbone classic read master feeding a small FIFO
// that presents {instr, pc, err} to the CPU fetch port, with flush/redirect support.
module wb_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          flush_i,
    input  logic [31:0]   flush_adr_i,
    output logic [31:0]   instr_o,
    output logic [31:0]   pc_o,
    output logic          err_o,
    output logic          valid_o,
    input  logic          ready_i,
    wb_prefetch_if.master wbm
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] RESET_ADR = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_ptr;
    logic [31:0]     r_adr;
    logic [31:0]     w_ptr_inc;
    logic [31:0]     w_flush_adr;

    logic [31:0]     r_dat [DEPTH];
    logic [31:0]     r_pc  [DEPTH];
    logic [DEPTH-1:0] r_errv;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    logic            w_term;
    logic            w_push;
    logic            w_pop;
    logic            w_space_idle;
    logic            w_space_more;
    logic            w_issue;

    assign w_term       = wbm.wbm_ack_i | wbm.wbm_err_i;
    assign w_push       = (r_state == S_REQ) && w_term && !flush_i;
    assign w_pop        = valid_o && ready_i && !flush_i;
    assign w_ptr_inc    = r_ptr + 32'd4;
    assign w_flush_adr  = flush_adr_i & 32'hFFFF_FFFC;

    // Space is judged on the current count only; a same-cycle pop is not credited.
    assign w_space_idle = (r_count < DEPTH_C);
    assign w_space_more = (r_count < DEPTH_M1_C);

    assign w_issue = (w_state_nxt == S_REQ) && ((r_state == S_IDLE) || w_push);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!flush_i && w_space_idle) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_term) begin
                    if (flush_i || !w_space_more) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (flush_i) begin
                    // The slave still owes an ack; it must be absorbed before a new cycle.
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_term) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: cyc/stb decode straight from the state register
    always_comb begin
        wbm.wbm_cyc_o = 1'b0;
        wbm.wbm_stb_o = 1'b0;
        if (r_state != S_IDLE) begin
            wbm.wbm_cyc_o = 1'b1;
            wbm.wbm_stb_o = 1'b1;
        end
    end

    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_sel_o = 4'hF;
    assign wbm.wbm_cti_o = 3'b000;
    assign wbm.wbm_bte_o = 2'b00;
    assign wbm.wbm_we_o  = 1'b0;

    // Fetch pointer and bus address; adr stays frozen through DRAIN while ptr takes the redirect.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ptr <= RESET_ADR;
            r_adr <= RESET_ADR;
        end else begin
            if (flush_i) begin
                r_ptr <= w_flush_adr;
            end else if (w_push) begin
                r_ptr <= w_ptr_inc;
            end
            if (w_issue) begin
                r_adr <= w_push ? w_ptr_inc : r_ptr;
            end
        end
    end

    // FIFO: flush wins over any simultaneous push or pop
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_errv  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
                r_pc[i]  <= '0;
            end
        end else if (flush_i) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
        end else begin
            if (w_push) begin
                r_dat[r_wr]  <= wbm.wbm_dat_i;
                r_pc[r_wr]   <= r_adr;
                r_errv[r_wr] <= wbm.wbm_err_i;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid_o = (r_count != '0);
    assign instr_o = r_dat[r_rd];
    assign pc_o    = r_pc[r_rd];
    assign err_o   = r_errv[r_rd];

endmodule

// File: tb/tb_wb_prefetch.sv
// Directed bench for wb_prefetch against a registered-ack boot ROM model (word n = A000_0000+n).
module tb_wb_prefetch;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        flush_i;
    logic [31:0] flush_adr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        err_o;
    logic        valid_o;
    logic        ready_i;

    logic        stall;
    logic        err_en;
    logic [31:0] err_adr;
    logic        mon_stb;
    int          stb_base;
    int          stb_gap = 0;

    int checks = 0;
    int errors = 0;
    int abase;
    int pbase;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } pop_t;

    logic [31:0] ack_adr_q [$];
    pop_t        pop_q [$];

    wb_prefetch_if bus ();

    wb_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .flush_i     (flush_i),
        .flush_adr_i (flush_adr_i),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .err_o       (err_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .wbm         (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Boot ROM: registered ack one cycle after stb, err on a chosen address, optional stall.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            bus.wbm_dat_i <= 32'h0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && !bus.wbm_err_i && !stall) begin
            bus.wbm_dat_i <= 32'hA000_0000 + (bus.wbm_adr_o >> 2);
            if (err_en && (bus.wbm_adr_o == err_adr)) begin
                bus.wbm_err_i <= 1'b1;
            end else begin
                bus.wbm_ack_i <= 1'b1;
            end
        end else begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
        end
    end

    // Observe terminations and accepted words mid-cycle, ahead of the edge that consumes them.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (bus.wbm_cyc_o && (bus.wbm_ack_i || bus.wbm_err_i))
                ack_adr_q.push_back(bus.wbm_adr_o);
            if (valid_o && ready_i && !flush_i)
                pop_q.push_back('{instr: instr_o, pc: pc_o, err: err_o});
            if (mon_stb && (ack_adr_q.size() > stb_base) && !bus.wbm_stb_o)
                stb_gap++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ack_at(input int i);
        if (i < ack_adr_q.size()) return ack_adr_q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic pop_t pop_at(input int i);
        if (i < pop_q.size()) return pop_q[i];
        return '1;
    endfunction

    task automatic do_reset();
        wb_rst_i = 1'b1;
        step(2);
        wb_rst_i = 1'b0;
        abase = ack_adr_q.size();
        pbase = pop_q.size();
    endtask

    initial begin
        wb_rst_i = 1'b0; flush_i = 1'b0; flush_adr_i = 32'h0; ready_i = 1'b0;
        stall = 1'b0; err_en = 1'b0; err_adr = 32'h0; mon_stb = 1'b0; stb_base = 0;

        // Reset values
        #1 wb_rst_i = 1'b1;
        #2;
        chk("rst_cyc",   32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb",   32'(bus.wbm_stb_o), 32'd0);
        chk("rst_adr",   bus.wbm_adr_o,      32'h0);
        chk("rst_valid", 32'(valid_o),       32'd0);
        chk("rst_instr", instr_o,            32'h0);
        chk("rst_pc",    pc_o,               32'h0);
        chk("rst_err",   32'(err_o),         32'd0);
        chk("const_sel", 32'(bus.wbm_sel_o), 32'hF);
        chk("const_cti", 32'(bus.wbm_cti_o), 32'd0);
        chk("const_bte", 32'(bus.wbm_bte_o), 32'd0);
        chk("const_we",  32'(bus.wbm_we_o),  32'd0);
        step(2);
        wb_rst_i = 1'b0;
        abase = ack_adr_q.size();
        pbase = pop_q.size();

        // Back-pressure: FIFO fills with exactly DEPTH words, one pop frees one request
        step(20);
        chk("bp_acks",    32'(ack_adr_q.size() - abase), 32'd4);
        chk("bp_adr0",    ack_at(abase + 0), 32'h0);
        chk("bp_adr3",    ack_at(abase + 3), 32'hC);
        chk("bp_cyc",     32'(bus.wbm_cyc_o), 32'd0);
        chk("bp_valid",   32'(valid_o), 32'd1);
        chk("bp_instr",   instr_o, 32'hA000_0000);
        chk("bp_pc",      pc_o, 32'h0);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        step(10);
        chk("bp_pops",    32'(pop_q.size() - pbase), 32'd1);
        chk("bp_pop_pc",  pop_at(pbase).pc, 32'h0);
        chk("bp_acks2",   32'(ack_adr_q.size() - abase), 32'd5);
        chk("bp_adr4",    ack_at(abase + 4), 32'h10);
        chk("bp_cyc2",    32'(bus.wbm_cyc_o), 32'd0);
        chk("bp_instr2",  instr_o, 32'hA000_0001);
        chk("bp_pc2",     pc_o, 32'h4);

        // Reset in the middle of a request with three words buffered
        do_reset();
        step(7);
        chk("mid_cyc",    32'(bus.wbm_cyc_o), 32'd1);
        chk("mid_adr",    bus.wbm_adr_o, 32'hC);
        chk("mid_valid",  32'(valid_o), 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("arst_cyc",   32'(bus.wbm_cyc_o), 32'd0);
        chk("arst_stb",   32'(bus.wbm_stb_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_adr",   bus.wbm_adr_o, 32'h0);
        step(2);
        wb_rst_i = 1'b0;
        ready_i = 1'b1;
        abase = ack_adr_q.size();
        pbase = pop_q.size();

        // Streaming with the consumer always ready
        stb_base = abase;
        mon_stb = 1'b1;
        step(20);
        mon_stb = 1'b0;
        chk("str_first_adr", ack_at(abase), 32'h0);
        chk("str_stb_gap",   32'(stb_gap), 32'd0);
        chk("str_count_ok",  32'(pop_q.size() - pbase >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("str_instr%0d", i), pop_at(pbase + i).instr, 32'hA000_0000 + 32'(i));
            chk($sformatf("str_pc%0d", i),    pop_at(pbase + i).pc,    32'(4 * i));
            chk($sformatf("str_err%0d", i),   32'(pop_at(pbase + i).err), 32'd0);
        end

        // Error termination on the fetch at 0x8
        err_adr = 32'h8;
        err_en = 1'b1;
        do_reset();
        step(20);
        err_en = 1'b0;
        chk("err_pc1",    pop_at(pbase + 1).pc, 32'h4);
        chk("err_e1",     32'(pop_at(pbase + 1).err), 32'd0);
        chk("err_pc2",    pop_at(pbase + 2).pc, 32'h8);
        chk("err_e2",     32'(pop_at(pbase + 2).err), 32'd1);
        chk("err_instr2", pop_at(pbase + 2).instr, 32'hA000_0002);
        chk("err_pc3",    pop_at(pbase + 3).pc, 32'hC);
        chk("err_e3",     32'(pop_at(pbase + 3).err), 32'd0);
        chk("err_instr3", pop_at(pbase + 3).instr, 32'hA000_0003);

        // Flush while a request is outstanding: drain, discard, refetch at 0x100
        ready_i = 1'b0;
        do_reset();
        step(5);
        stall = 1'b1;
        step(2);
        chk("fl_pre_cyc",   32'(bus.wbm_cyc_o), 32'd1);
        chk("fl_pre_adr",   bus.wbm_adr_o, 32'h8);
        chk("fl_pre_valid", 32'(valid_o), 32'd1);
        flush_i = 1'b1;
        flush_adr_i = 32'h103;
        step(1);
        flush_i = 1'b0;
        ready_i = 1'b1;
        chk("fl_valid",  32'(valid_o), 32'd0);
        chk("fl_cyc",    32'(bus.wbm_cyc_o), 32'd1);
        chk("fl_stb",    32'(bus.wbm_stb_o), 32'd1);
        chk("fl_adr",    bus.wbm_adr_o, 32'h8);
        step(2);
        chk("fl_hold_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        chk("fl_hold_adr", bus.wbm_adr_o, 32'h8);
        stall = 1'b0;
        step(2);
        chk("fl_idle_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        step(1);
        chk("fl_new_cyc",  32'(bus.wbm_cyc_o), 32'd1);
        chk("fl_new_adr",  bus.wbm_adr_o, 32'h100);
        step(10);
        chk("fl_drain_ack", ack_at(abase + 2), 32'h8);
        chk("fl_next_ack",  ack_at(abase + 3), 32'h100);
        chk("fl_pop_pc0",   pop_at(pbase).pc, 32'h100);
        chk("fl_pop_in0",   pop_at(pbase).instr, 32'hA000_0040);
        chk("fl_pop_pc1",   pop_at(pbase + 1).pc, 32'h104);

        // Flush coinciding with an ack and a pop
        ready_i = 1'b0;
        do_reset();
        step(4);
        flush_i = 1'b1;
        flush_adr_i = 32'h40;
        ready_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        chk("fa_cyc",    32'(bus.wbm_cyc_o), 32'd0);
        chk("fa_valid",  32'(valid_o), 32'd0);
        step(1);
        chk("fa_cyc2",   32'(bus.wbm_cyc_o), 32'd1);
        chk("fa_adr",    bus.wbm_adr_o, 32'h40);
        step(8);
        chk("fa_ack1",   ack_at(abase + 1), 32'h4);
        chk("fa_ack2",   ack_at(abase + 2), 32'h40);
        chk("fa_pop_pc", pop_at(pbase).pc, 32'h40);
        chk("fa_pop_in", pop_at(pbase).instr, 32'hA000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
